// File: rtl/mix_columns_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES MixColumns block.
package mix_columns_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] GF_RED = 8'h1B;

    // First matrix row; row r uses these coefficients rotated right by r.
    localparam logic [7:0] FWD_ROW [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_ROW [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

    // All matrix coefficients fit in 4 bits, so four partial products suffice.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_word.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
module mix_column_word
    import mix_columns_seq_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] b [4];

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            b[j] = col_in[31 - 8*j -: 8];
        end
    end

    // NOTE: col_out gets a full default first so no path through the loop can infer a latch.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                col_out[31 - 8*r -: 8] = col_out[31 - 8*r -: 8] ^
                    gf_mul(b[j], inv ? INV_ROW[(j - r + 4) % 4][3:0]
                                     : FWD_ROW[(j - r + 4) % 4][3:0]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle through a shared column unit.
module mix_columns_seq
    import mix_columns_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         inv_q, inv_d;
    logic [127:0] work_q, work_d;
    logic [127:0] result_q, result_d;
    logic [31:0]  col_word, col_mixed;

    mix_column_word u_word (
        .col_in  (col_word),
        .inv     (inv_q),
        .col_out (col_mixed)
    );

    assign col_word = work_q[127 - 32*int'(col_q) -: 32];

    // NOTE: sequential state uses non-blocking assignments; the working and result
    // registers are plain flops here, so they are reset along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            col_q    <= 2'd0;
            inv_q    <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            inv_q    <= inv_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)      state_d = ST_BUSY;
            ST_BUSY: if (col_q == 2'd3) state_d = ST_DONE;
            ST_DONE: if (out_ready)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d    = col_q;
        inv_d    = inv_q;
        work_d   = work_q;
        result_d = result_q;
        if (state_q == ST_IDLE && in_valid) begin
            work_d = in_state;
            inv_d  = in_inv;
            col_d  = 2'd0;
        end else if (state_q == ST_BUSY) begin
            result_d[127 - 32*int'(col_q) -: 32] = col_mixed;
            col_d = col_q + 2'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    assign out_state = result_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: known vectors, corner sequences, random stream.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_inv;
    logic [127:0] in_state;
    logic         out_valid, out_ready, busy;
    logic [127:0] out_state;

    int vectors = 0;
    int miscompares = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] FWD_M [4][4] = '{
        '{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
        '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    localparam logic [7:0] INV_M [4][4] = '{
        '{8'h0E, 8'h0B, 8'h0D, 8'h09}, '{8'h09, 8'h0E, 8'h0B, 8'h0D},
        '{8'h0D, 8'h09, 8'h0E, 8'h0B}, '{8'h0B, 8'h0D, 8'h09, 8'h0E}};

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= ref_mul(s[127 - 32*c - 8*j -: 8], inv ? INV_M[r][j] : FWD_M[r][j]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge raising out_valid.
    task automatic run_op(input logic [127:0] s, input logic inv, input bit noise,
                          output logic [127:0] res, output int lat);
        check("ready_before_accept", 128'(in_ready), 128'd1);
        in_state = s; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (noise) begin
                in_state = rand128();
                in_inv   = 1'($urandom());
                in_valid = 1'($urandom());
                out_ready = 1'($urandom());
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        res = out_state;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_handshake", {in_ready, out_valid, busy}, 128'b100);
    endtask

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    logic [127:0] res, held, captured, exp_q [$];
    int           lat;
    bit           saw_valid;

    initial begin
        tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                   128'hdb135345_f20a225c_01010101_c6c6c6c6};
        tbl[2] = '{{4{32'hffffffff}}, 1'b0, {4{32'hffffffff}}};
        tbl[3] = '{128'h0, 1'b1, 128'h0};
        tbl[4] = '{128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0,
                   128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d};

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_flags", {in_ready, out_valid, busy}, 128'b100);
        check("reset_out_state", out_state, 128'h0);
        rst = 1'b0;

        // Table vectors; the first accept lands on the first edge after reset release.
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].din, tbl[i].inv, 1'b0, res, lat);
            check($sformatf("latency_vec%0d", i), 128'(lat), 128'd4);
            check($sformatf("result_vec%0d", i), res, tbl[i].exp);
            release_out();
        end

        // Backpressure: hold DONE for 10 cycles.
        run_op(tbl[0].din, 1'b0, 1'b0, held, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_flags", {in_ready, out_valid, busy}, 128'b011);
            check("bp_stable", out_state, held);
        end
        release_out();

        // Input noise during BUSY.
        for (int i = 0; i < 4; i++) begin
            captured = rand128();
            run_op(captured, 1'(i), 1'b1, res, lat);
            check("noise_latency", 128'(lat), 128'd4);
            check("noise_result", res, ref_mix(captured, 1'(i)));
            release_out();
        end

        // Reset two edges after accept.
        in_state = rand128(); in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midop_reset_flags", {in_ready, out_valid, busy}, 128'b100);
        check("midop_reset_out", out_state, 128'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_valid_after_reset", 128'(saw_valid), 128'd0);
        captured = rand128();
        run_op(captured, 1'b1, 1'b0, res, lat);
        check("post_reset_result", res, ref_mix(captured, 1'b1));
        release_out();

        // Streaming: 100 states, in_valid and out_ready held high.
        begin
            int  cyc = 0, last_acc = -1, accepts = 0, results = 0;
            bit  acc, fire;
            logic [127:0] samp;
            logic         samp_inv;
            in_valid = 1'b1; out_ready = 1'b1;
            in_state = rand128(); in_inv = 1'($urandom());
            while (results < 100 && cyc < 800) begin
                @(negedge clk);
                acc  = in_valid && in_ready;
                fire = out_valid && out_ready;
                samp = out_state;
                samp_inv = in_inv;
                if (acc) exp_q.push_back(ref_mix(in_state, samp_inv));
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    if (last_acc >= 0) check("stream_spacing", 128'(cyc - last_acc), 128'd6);
                    last_acc = cyc;
                    accepts++;
                    in_state = rand128(); in_inv = 1'($urandom());
                    if (accepts == 100) in_valid = 1'b0;
                end
                if (fire) begin
                    if (exp_q.size() == 0) check("stream_spurious", 128'd1, 128'd0);
                    else check("stream_result", samp, exp_q.pop_front());
                    results++;
                end
            end
            check("stream_count", 128'(results), 128'd100);
            in_valid = 1'b0; out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
